// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: shares one synchronous font ROM between the real-time pixel
// path (P, priority) and the status-text engine (S, bounded wait, forced grant).
module font_rom_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int S_MAX_WAIT = 16,
  parameter int MISS_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              s_gnt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] p_data,
  output logic              p_valid,
  output logic              p_miss,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [1:0]        fsm_state
);

  // Handshake: S holds s_req high with s_addr stable until the cycle s_gnt is
  // high; that cycle's read completes with s_valid three cycles later.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } s_state_t;

  localparam logic [7:0]        MAX_WAIT = 8'(S_MAX_WAIT);
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  s_state_t   state, state_next;
  logic [7:0] wait_cnt, wait_next;
  logic       p_req, grant_p, grant_s, miss;
  logic [2:0] tag1, tag2;  // {p, s, miss}

  assign p_req     = |p_addr;
  assign s_gnt     = grant_s;
  assign fsm_state = state;

  always_comb begin
    grant_p = 1'b0;
    grant_s = 1'b0;
    miss    = 1'b0;
    if (!rst) begin
      if (state == S_FORCE && s_req) begin
        grant_s = 1'b1;
        miss    = p_req;
      end else if (p_req) begin
        grant_p = 1'b1;
      end else if (s_req) begin
        grant_s = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (s_req && !grant_s) begin
          wait_next  = 8'd1;
          state_next = (MAX_WAIT <= 8'd1) ? S_FORCE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!s_req || grant_s) begin
          wait_next  = 8'd0;
          state_next = S_IDLE;
        end else begin
          wait_next = wait_cnt + 8'd1;
          if (wait_next >= MAX_WAIT) state_next = S_FORCE;
        end
      end
      default: begin
        wait_next  = 8'd0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      rom_addr <= '0;
      tag1     <= 3'b000;
      tag2     <= 3'b000;
      p_data   <= '0;
      s_data   <= '0;
      p_valid  <= 1'b0;
      s_valid  <= 1'b0;
      p_miss   <= 1'b0;
      miss_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      rom_addr <= grant_s ? s_addr : (grant_p ? p_addr : '0);
      tag1     <= {grant_p, grant_s, miss};
      tag2     <= tag1;
      // tag2 belongs to the read whose ROM row is on rom_data now
      p_valid  <= tag2[2];
      s_valid  <= tag2[1];
      p_miss   <= tag2[0];
      if (tag2[2]) p_data <= rom_data;
      if (tag2[1]) s_data <= rom_data;
      if (tag2[0] && miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + MISS_ONE;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed test-plan steps plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_font_rom_arbiter;
  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int S_MAX_WAIT = 16;
  localparam int MISS_W     = 4;
  localparam int MISS_SAT   = (1 << MISS_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] p_addr = '0;
  logic              s_req = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic              s_gnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0] p_data;
  logic              p_valid;
  logic              p_miss;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic [MISS_W-1:0] miss_cnt;
  logic [1:0]        fsm_state;

  font_rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .S_MAX_WAIT(S_MAX_WAIT), .MISS_W(MISS_W)
  ) dut (
    .clk(clk), .rst(rst), .p_addr(p_addr), .s_req(s_req), .s_addr(s_addr),
    .s_gnt(s_gnt), .rom_addr(rom_addr), .rom_data(rom_data), .p_data(p_data),
    .p_valid(p_valid), .p_miss(p_miss), .s_data(s_data), .s_valid(s_valid),
    .miss_cnt(miss_cnt), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // reference model: event word {grant_p, grant_s, miss, addr}
  localparam int EW = ADDR_W + 3;
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] exp_p_data, exp_s_data;
  int                pend, misses;
  int                checks = 0, errors = 0;
  bit                started = 0;
  logic              last_gs, obs_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    exp_p_data = '0;
    exp_s_data = '0;
    pend = 0;
    misses = 0;
  endtask

  // one clock cycle: evaluate model and check at negedge, advance at posedge
  task automatic cycle();
    logic [EW-1:0] front, ev;
    logic gp, gs, ms, pr;
    int exp_state, exp_cnt;
    @(negedge clk);
    pr = (p_addr != '0);
    gp = 1'b0; gs = 1'b0; ms = 1'b0;
    if (!rst) begin
      if (pend >= S_MAX_WAIT && s_req) begin gs = 1'b1; ms = pr; end
      else if (pr) gp = 1'b1;
      else if (s_req) gs = 1'b1;
    end
    ev = {gp, gs, ms, gs ? s_addr : (gp ? p_addr : '0)};
    front = exp_q[0];
    if (front[EW-1]) exp_p_data = rom[front[ADDR_W-1:0]];
    if (front[EW-2]) exp_s_data = rom[front[ADDR_W-1:0]];
    if (front[EW-3]) misses++;
    exp_cnt = (misses > MISS_SAT) ? MISS_SAT : misses;
    exp_state = (pend == 0) ? 0 : ((pend >= S_MAX_WAIT) ? 2 : 1);
    obs_gnt = s_gnt;
    last_gs = gs;
    if (started) begin
      check("s_gnt", 32'(s_gnt), 32'(gs));
      check("rom_addr", 32'(rom_addr), 32'(exp_q[2][ADDR_W-1:0]));
      check("p_valid", 32'(p_valid), 32'(front[EW-1]));
      check("s_valid", 32'(s_valid), 32'(front[EW-2]));
      check("p_miss", 32'(p_miss), 32'(front[EW-3]));
      check("p_data", 32'(p_data), 32'(exp_p_data));
      check("s_data", 32'(s_data), 32'(exp_s_data));
      check("miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
      check("fsm_state", 32'(fsm_state), 32'(exp_state));
    end
    void'(exp_q.pop_front());
    exp_q.push_back(ev);
    @(posedge clk);
    if (rst) model_clear();
    else if (s_req && !gs) pend++;
    else pend = 0;
    started = 1;
    #1;
  endtask

  task automatic idle(input int n);
    p_addr = '0;
    s_req  = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // S pending under continuous P traffic; returns cycles until DUT s_gnt
  task automatic contend(input logic [ADDR_W-1:0] addr, output int n);
    n = 0;
    s_req  = 1'b1;
    s_addr = addr;
    for (int i = 0; i < 40 && n == 0; i++) begin
      p_addr = ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1));
      cycle();
      if (obs_gnt) n = i + 1;
    end
    s_req = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = DATA_W'($urandom);
    rom[11'h413] = 8'h18;
    model_clear();

    // reset with both requesters active
    rst = 1'b1; p_addr = 11'h405; s_req = 1'b1; s_addr = 11'h6B2;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    idle(4);

    // P only
    p_addr = 11'h413;
    cycle();
    idle(4);
    check("p_row_a3", 32'(p_data), 32'h18);

    // S only, granted immediately
    s_req = 1'b1; s_addr = 11'h6B2;
    cycle();
    idle(4);

    // contention: forced grant after S_MAX_WAIT pending cycles
    contend(11'h123, n);
    check("force_latency", 32'(n), 32'(S_MAX_WAIT + 1));
    for (int i = 0; i < 5; i++) begin
      p_addr = ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1));
      cycle();
    end
    idle(3);
    check("miss_one", 32'(miss_cnt), 32'd1);

    // saturation of the miss counter
    for (int k = 0; k < 20; k++) begin
      contend(ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1)), n);
      check("force_latency_loop", 32'(n), 32'(S_MAX_WAIT + 1));
    end
    idle(4);
    check("miss_sat", 32'(miss_cnt), 32'(MISS_SAT));

    // reset while an S read is in flight
    s_req = 1'b1; s_addr = 11'h2A7; p_addr = '0;
    cycle();
    s_req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(4);
    check("rst_s_data", 32'(s_data), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);

    // random traffic honouring the S hold-until-grant protocol
    for (int i = 0; i < 400; i++) begin
      p_addr = ($urandom_range(0, 2) == 0) ? '0 : ADDR_W'($urandom);
      if (s_req && last_gs) begin
        s_req  = ($urandom_range(0, 1) == 1);
        s_addr = ADDR_W'($urandom);
      end else if (s_req) begin
        if ($urandom_range(0, 49) == 0) s_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        s_req  = 1'b1;
        s_addr = ADDR_W'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
